// File: rtl/fp_align_stage.sv
// Two-stage FP add/sub front end: unpacks IEEE-754 singles, orders operands by magnitude,
// aligns the smaller mantissa to the larger exponent and flags NaN/Inf results.
module fp_align_stage #(
  parameter int unsigned STICKY_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] man_big,
  output logic [24:0] man_small,
  output logic [7:0]  exp_out,
  output logic        sign_big,
  output logic        eff_sub,
  output logic        sticky,
  output logic        special,
  output logic [31:0] special_res
);

  localparam int unsigned MW = 25;
  localparam int unsigned EW = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic s2_adv;
  logic s1_valid;

  // Stage 1 registers
  logic [MW-1:0] s1_man_big, s1_man_small;
  logic [EW-1:0] s1_exp, s1_d;
  logic          s1_sign_big, s1_eff_sub, s1_special;
  logic [31:0]   s1_res;

  // Stage 1 combinational results
  logic [MW-1:0] a_man, b_man, c1_man_big, c1_man_small;
  logic [EW-1:0] a_exp_eff, b_exp_eff, c1_exp, c1_d;
  logic          b_sign_eff, a_is_big, a_nan, b_nan, a_inf, b_inf;
  logic          c1_sign_big, c1_eff_sub, c1_special;
  logic [31:0]   c1_res;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Unpack, magnitude compare, swap, exponent difference and special detection
  always_comb begin
    a_man        = {|a[30:23], a[22:0], 1'b0};
    b_man        = {|b[30:23], b[22:0], 1'b0};
    a_exp_eff    = (a[30:23] == '0) ? EW'(1) : a[30:23];
    b_exp_eff    = (b[30:23] == '0) ? EW'(1) : b[30:23];
    b_sign_eff   = b[31] ^ sub;
    c1_eff_sub   = a[31] ^ b_sign_eff;
    a_is_big     = a[30:0] >= b[30:0];
    a_nan        = (a[30:23] == '1) && (a[22:0] != '0);
    b_nan        = (b[30:23] == '1) && (b[22:0] != '0);
    a_inf        = (a[30:23] == '1) && (a[22:0] == '0);
    b_inf        = (b[30:23] == '1) && (b[22:0] == '0);
    c1_man_big   = a_is_big ? a_man : b_man;
    c1_man_small = a_is_big ? b_man : a_man;
    c1_exp       = a_is_big ? a[30:23] : b[30:23];
    c1_sign_big  = a_is_big ? a[31] : b_sign_eff;
    c1_d         = a_is_big ? (a_exp_eff - b_exp_eff) : (b_exp_eff - a_exp_eff);
    c1_special   = a_nan || b_nan || a_inf || b_inf;
    c1_res       = '0;
    if (a_nan || b_nan || (a_inf && b_inf && c1_eff_sub)) c1_res = QNAN;
    else if (a_inf)                                       c1_res = {a[31], 8'hFF, 23'd0};
    else if (b_inf)                                       c1_res = {b_sign_eff, 8'hFF, 23'd0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_man_big   <= '0;
      s1_man_small <= '0;
      s1_exp       <= '0;
      s1_d         <= '0;
      s1_sign_big  <= 1'b0;
      s1_eff_sub   <= 1'b0;
      s1_special   <= 1'b0;
      s1_res       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_man_big   <= c1_man_big;
        s1_man_small <= c1_man_small;
        s1_exp       <= c1_exp;
        s1_d         <= c1_d;
        s1_sign_big  <= c1_sign_big;
        s1_eff_sub   <= c1_eff_sub;
        s1_special   <= c1_special;
        s1_res       <= c1_res;
      end
    end
  end

  // Stage 2: alignment shift with sticky collection, special-result muxing
  logic [2*MW-1:0] shifted;
  logic [MW-1:0]   c2_man_small;
  logic            c2_sticky_raw, c2_sticky;

  always_comb begin
    shifted = {s1_man_small, MW'(0)} >> s1_d;
    if (s1_d >= EW'(MW)) begin
      c2_man_small  = '0;
      c2_sticky_raw = |s1_man_small;
    end else begin
      c2_man_small  = shifted[2*MW-1:MW];
      c2_sticky_raw = |shifted[MW-1:0];
    end
    c2_sticky = (STICKY_EN != 0) && !s1_special && c2_sticky_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      man_big     <= '0;
      man_small   <= '0;
      exp_out     <= '0;
      sign_big    <= 1'b0;
      eff_sub     <= 1'b0;
      sticky      <= 1'b0;
      special     <= 1'b0;
      special_res <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        man_big     <= s1_special ? '0 : s1_man_big;
        man_small   <= s1_special ? '0 : c2_man_small;
        exp_out     <= s1_exp;
        sign_big    <= s1_sign_big;
        eff_sub     <= s1_eff_sub;
        sticky      <= c2_sticky;
        special     <= s1_special;
        special_res <= s1_special ? s1_res : '0;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Bench for fp_align_stage: table of hand-computed vectors pushed to a scoreboard on
// acceptance, plus backpressure and mid-flight reset sequences.
module tb_fp_align_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, special_res;
  logic [24:0] man_big, man_small;
  logic [7:0]  exp_out;
  logic        sign_big, eff_sub, sticky, special;

  fp_align_stage #(.STICKY_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .man_big(man_big), .man_small(man_small), .exp_out(exp_out),
    .sign_big(sign_big), .eff_sub(eff_sub), .sticky(sticky),
    .special(special), .special_res(special_res)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a, b;
    logic        sub;
    logic [24:0] mb, ms;
    logic [7:0]  ex;
    logic        sg, es, st, sp;
    logic [31:0] res;
  } vec_t;

  typedef struct packed {
    vec_t v;
    int   acc_cyc;
  } exp_t;

  vec_t tbl [14];
  exp_t sbq [$];
  int   total = 0, bad = 0, cyc = 0, outs = 0, stalls = 0;
  logic chk_lat = 1'b0, hold_pending = 1'b0, last_acc;
  logic [127:0] snap;

  function automatic vec_t mk(input logic [31:0] va, vb, input logic vs,
                              input logic [24:0] mb, ms, input logic [7:0] ex,
                              input logic sg, es, st, sp, input logic [31:0] res);
    mk = '{a: va, b: vb, sub: vs, mb: mb, ms: ms, ex: ex, sg: sg, es: es, st: st, sp: sp, res: res};
  endfunction

  function automatic logic [127:0] cur_out();
    cur_out = {33'd0, man_big, man_small, exp_out, sign_big, eff_sub, sticky, special, special_res};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic compare_out(input exp_t e);
    check("man_big",     128'(man_big),     128'(e.v.mb));
    check("man_small",   128'(man_small),   128'(e.v.ms));
    check("exp_out",     128'(exp_out),     128'(e.v.ex));
    check("sign_big",    128'(sign_big),    128'(e.v.sg));
    check("eff_sub",     128'(eff_sub),     128'(e.v.es));
    check("sticky",      128'(sticky),      128'(e.v.st));
    check("special",     128'(special),     128'(e.v.sp));
    check("special_res", 128'(special_res), 128'(e.v.res));
    if (chk_lat) check("latency", 128'(cyc - e.acc_cyc), 128'(2));
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, advance to next falling edge
  task automatic tick(input logic v, input int idx, input logic ordy);
    exp_t e;
    in_valid  = v;
    out_ready = ordy;
    if (idx >= 0) begin
      a = tbl[idx].a; b = tbl[idx].b; sub = tbl[idx].sub;
    end else begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(1));
    end
    #1;
    last_acc = 1'b0;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("hold_stable", cur_out(), snap);
      hold_pending = out_valid && !out_ready;
      snap = cur_out();
      if (in_valid && !in_ready) stalls++;
      if (out_valid && out_ready) begin
        outs++;
        if (sbq.size() == 0) check("unexpected_out", 128'(1), 128'(0));
        else begin
          e = sbq.pop_front();
          compare_out(e);
        end
      end
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        e.v = tbl[idx];
        e.acc_cyc = cyc;
        sbq.push_back(e);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, outs0;
    tbl[0]  = mk(32'h3F800000, 32'h40000000, 1'b0, 25'h1000000, 25'h0800000, 8'h80, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(32'h4B800000, 32'h3F800000, 1'b0, 25'h1000000, 25'h0000001, 8'h97, 0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(32'h4C800000, 32'h3F800001, 1'b0, 25'h1000000, 25'h0000000, 8'h99, 0, 0, 1, 0, 32'h0);
    tbl[3]  = mk(32'h40400000, 32'h40400000, 1'b1, 25'h1800000, 25'h1800000, 8'h80, 0, 1, 0, 0, 32'h0);
    tbl[4]  = mk(32'h7F800000, 32'h7F800000, 1'b1, 25'h0, 25'h0, 8'hFF, 0, 1, 0, 1, 32'h7FC00000);
    tbl[5]  = mk(32'hFF800000, 32'h3F800000, 1'b0, 25'h0, 25'h0, 8'hFF, 1, 1, 0, 1, 32'hFF800000);
    tbl[6]  = mk(32'h3F800000, 32'h7F800001, 1'b0, 25'h0, 25'h0, 8'hFF, 0, 0, 0, 1, 32'h7FC00000);
    tbl[7]  = mk(32'hC0000000, 32'h40A00000, 1'b1, 25'h1400000, 25'h0800000, 8'h81, 1, 0, 0, 0, 32'h0);
    tbl[8]  = mk(32'h40800000, 32'h3F800003, 1'b0, 25'h1000000, 25'h0400001, 8'h81, 0, 0, 1, 0, 32'h0);
    tbl[9]  = mk(32'h00400000, 32'h01000000, 1'b0, 25'h1000000, 25'h0400000, 8'h02, 0, 0, 0, 0, 32'h0);
    tbl[10] = mk(32'h4C000000, 32'h3F800000, 1'b0, 25'h1000000, 25'h0000000, 8'h98, 0, 0, 1, 0, 32'h0);
    tbl[11] = mk(32'h40400000, 32'hC0400000, 1'b0, 25'h1800000, 25'h1800000, 8'h80, 0, 1, 0, 0, 32'h0);
    tbl[12] = mk(32'h3F800000, 32'hBFC00000, 1'b0, 25'h1800000, 25'h1000000, 8'h7F, 1, 1, 0, 0, 32'h0);
    tbl[13] = mk(32'h3F800000, 32'h7F800000, 1'b1, 25'h0, 25'h0, 8'hFF, 1, 1, 0, 1, 32'hFF800000);

    // Power-on reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    @(negedge clk);
    tick(1'b1, 0, 1'b1);
    tick(1'b0, -1, 1'b1);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(1));
    check("rst_outputs",   cur_out(),       128'(0));
    @(negedge clk); cyc++;

    // Full table streamed back to back with downstream always ready
    chk_lat = 1'b1;
    for (int i = 0; i < 14; i++) tick(1'b1, i, 1'b1);
    repeat (3) tick(1'b0, -1, 1'b1);
    check("stream_drained", 128'(sbq.size()), 128'(0));
    check("stream_count",   128'(outs),       128'(14));

    // Backpressure: out_ready low on cycles 2-4 of a 4-op burst
    chk_lat = 1'b0;
    p = 0; stalls = 0; outs0 = outs;
    for (int k = 1; k <= 10; k++) begin
      tick(p < 4, (p < 4) ? p : -1, !(k >= 2 && k <= 4));
      if (last_acc) p++;
    end
    check("bp_accepted",  128'(p),             128'(4));
    check("bp_stalls",    128'(stalls),        128'(2));
    check("bp_out_count", 128'(outs - outs0),  128'(4));
    check("bp_drained",   128'(sbq.size()),    128'(0));

    // Reset with two operations in flight
    tick(1'b1, 7, 1'b0);
    tick(1'b1, 8, 1'b0);
    check("mid_two_queued", 128'(sbq.size()), 128'(2));
    rst = 1'b1;
    tick(1'b0, -1, 1'b0);
    rst = 1'b0;
    sbq.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_in_ready",  128'(in_ready),  128'(1));
    @(negedge clk); cyc++;
    chk_lat = 1'b1;
    outs0 = outs;
    tick(1'b1, 12, 1'b1);
    repeat (3) tick(1'b0, -1, 1'b1);
    check("mid_post_count", 128'(outs - outs0), 128'(1));
    check("mid_drained",    128'(sbq.size()),   128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
